// File: rtl/imager_pkg.sv
// Shared definitions for the imager frame scheduler: state codes, the
// frame-config record and the default block parameters.
package imager_pkg;

  localparam int          C_TBL_DEPTH = 8;
  localparam int          C_WDOG      = 16777216;
  localparam logic [31:0] C_EXP_DEF   = 32'd10;
  localparam logic [31:0] C_NPAT_DEF  = 32'd100;

  // One-hot-ish codes double as the externally visible status byte.
  typedef enum logic [7:0] {
    ST_IDLE    = 8'h00,
    ST_LOAD    = 8'h01,
    ST_RUN     = 8'h02,
    ST_ACK1    = 8'h04,
    ST_READOUT = 8'h08,
    ST_NEXT    = 8'h10,
    ST_STOP    = 8'h20
  } sched_state_t;

  typedef struct packed {
    logic [31:0] exposure;
    logic [31:0] npat;
  } frame_cfg_t;

endpackage

// File: rtl/imager_cfg_table.sv
// Frame-configuration table: flop-based storage with one write port and one
// combinational read port. Every entry returns to the defaults on reset.
module imager_cfg_table
  import imager_pkg::frame_cfg_t;
#(
  parameter int          DEPTH    = imager_pkg::C_TBL_DEPTH,
  parameter logic [31:0] EXP_DEF  = imager_pkg::C_EXP_DEF,
  parameter logic [31:0] NPAT_DEF = imager_pkg::C_NPAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_exp,
  input  logic [31:0] wr_npat,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_exp,
  output logic [31:0] rd_npat
);

  frame_cfg_t entries [DEPTH];

  // Table storage: reload defaults on reset, otherwise take one write per cycle.
  always_ff @(posedge clk) begin
    // NOTE: every entry is reset because a run may start before any write,
    // so the defaults must be architecturally visible; this is why the
    // table is built from flops rather than an inferred RAM.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments keep all flops updating from the
        // same pre-edge values, whatever order the statements appear in.
        entries[i] <= '{exposure: EXP_DEF, npat: NPAT_DEF};
      end
    end else if (we) begin
      entries[wr_addr] <= '{exposure: wr_exp, npat: wr_npat};
    end
  end

  assign rd_exp  = entries[rd_addr].exposure;
  assign rd_npat = entries[rd_addr].npat;

endmodule

// File: rtl/imager_frame_scheduler.sv
// Frame scheduler: sequences exposure, readout and next-frame handshakes for
// a run of frames, stepping through the frame-config table per frame.
module imager_frame_scheduler
  import imager_pkg::sched_state_t, imager_pkg::ST_IDLE, imager_pkg::ST_LOAD,
         imager_pkg::ST_RUN, imager_pkg::ST_ACK1, imager_pkg::ST_READOUT,
         imager_pkg::ST_NEXT, imager_pkg::ST_STOP;
#(
  parameter int          C_TBL_DEPTH = imager_pkg::C_TBL_DEPTH,
  parameter int          C_WDOG      = imager_pkg::C_WDOG,
  parameter logic [31:0] C_EXP_DEF   = imager_pkg::C_EXP_DEF,
  parameter logic [31:0] C_NPAT_DEF  = imager_pkg::C_NPAT_DEF
) (
  input  logic        CLKMPRE,
  input  logic        RESET,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_ADDR,
  input  logic [31:0] CFG_EXP,
  input  logic [31:0] CFG_NPAT,
  input  logic [2:0]  TBL_LAST,
  input  logic [15:0] NUM_FRAMES,
  input  logic        LOOP,
  input  logic        START,
  input  logic        ABORT,
  output logic        IMG_RESET,
  output logic [31:0] Exp_subc,
  output logic [31:0] Num_Pat,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  output logic        RO_START,
  input  logic        RO_DONE,
  output logic        BUSY,
  output logic [15:0] FRAME_CNT,
  output logic        ERR,
  output logic [7:0]  sched_stat
);

  localparam logic [31:0] WDOG_LAST = 32'(C_WDOG - 1);

  sched_state_t state;
  logic [2:0]   index;
  logic [2:0]   next_idx;
  logic [2:0]   rd_addr;
  logic [31:0]  rd_exp;
  logic [31:0]  rd_npat;
  logic [31:0]  wdog_cnt;
  logic [15:0]  cnt_inc;
  logic         tbl_we;

  assign next_idx   = (index == TBL_LAST) ? 3'd0 : index + 3'd1;
  // While a readout is finishing, look ahead so NEXT captures the wrapped entry.
  assign rd_addr    = (state == ST_READOUT) ? next_idx : index;
  assign cnt_inc    = FRAME_CNT + 16'd1;
  assign tbl_we     = CFG_WE && (state == ST_IDLE);
  // State flops carry the status codes directly, so the status is registered.
  assign sched_stat = state;

  imager_cfg_table #(
    .DEPTH    (C_TBL_DEPTH),
    .EXP_DEF  (C_EXP_DEF),
    .NPAT_DEF (C_NPAT_DEF)
  ) u_cfg_table (
    .clk     (CLKMPRE),
    .rst     (RESET),
    .we      (tbl_we),
    .wr_addr (CFG_ADDR),
    .wr_exp  (CFG_EXP),
    .wr_npat (CFG_NPAT),
    .rd_addr (rd_addr),
    .rd_exp  (rd_exp),
    .rd_npat (rd_npat)
  );

  // Shared exit path: park the exposure FSM and drop every handshake at once.
  task automatic enter_stop();
    state      <= ST_STOP;
    IMG_RESET  <= 1'b1;
    FSMIND0    <= 1'b0;
    FSMIND1ACK <= 1'b0;
    BUSY       <= 1'b0;
  endtask

  // Run sequencer with registered outputs; ABORT pre-empts every transition.
  always_ff @(posedge CLKMPRE) begin
    if (RESET) begin
      state      <= ST_IDLE;
      IMG_RESET  <= 1'b1;
      Exp_subc   <= '0;
      Num_Pat    <= '0;
      FSMIND1ACK <= 1'b0;
      FSMIND0    <= 1'b0;
      RO_START   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_CNT  <= '0;
      ERR        <= 1'b0;
      index      <= '0;
      wdog_cnt   <= '0;
    end else begin
      RO_START <= 1'b0;
      if (ABORT && (state != ST_IDLE)) begin
        enter_stop();
      end else begin
        case (state)
          ST_IDLE: begin
            if (START) begin
              if ((NUM_FRAMES == 16'd0) && !LOOP) begin
                ERR <= 1'b1;
              end else begin
                index     <= '0;
                FRAME_CNT <= '0;
                ERR       <= 1'b0;
                state     <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            Exp_subc  <= rd_exp;
            Num_Pat   <= rd_npat;
            IMG_RESET <= 1'b0;
            BUSY      <= 1'b1;
            wdog_cnt  <= '0;
            state     <= ST_RUN;
          end
          ST_RUN: begin
            if (FSMIND1) begin
              state <= ST_ACK1;
            end else if (wdog_cnt == WDOG_LAST) begin
              ERR <= 1'b1;
              enter_stop();
            end else begin
              wdog_cnt <= wdog_cnt + 32'd1;
            end
          end
          ST_ACK1: begin
            FSMIND1ACK <= 1'b1;
            RO_START   <= 1'b1;
            state      <= ST_READOUT;
          end
          ST_READOUT: begin
            if (RO_DONE) begin
              FRAME_CNT <= cnt_inc;
              if (LOOP || (cnt_inc < NUM_FRAMES)) begin
                index    <= next_idx;
                Exp_subc <= rd_exp;
                Num_Pat  <= rd_npat;
                FSMIND0  <= 1'b1;
                state    <= ST_NEXT;
              end else begin
                enter_stop();
              end
            end
          end
          ST_NEXT: begin
            if (FSMIND0ACK) begin
              FSMIND0    <= 1'b0;
              FSMIND1ACK <= 1'b0;
              wdog_cnt   <= '0;
              state      <= ST_RUN;
            end
          end
          ST_STOP: state <= ST_IDLE;
          default: enter_stop();
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imager_frame_scheduler.sv
// Scoreboard bench for imager_frame_scheduler: stimulus pushes the expected
// per-frame table values and per-run results; a monitor pops and compares
// them on each RO_START pulse and each STOP state.
module tb_imager_frame_scheduler;

  localparam int WDOG = 64;

  logic        CLKMPRE = 1'b0;
  logic        RESET;
  logic        CFG_WE;
  logic [2:0]  CFG_ADDR;
  logic [31:0] CFG_EXP;
  logic [31:0] CFG_NPAT;
  logic [2:0]  TBL_LAST;
  logic [15:0] NUM_FRAMES;
  logic        LOOP;
  logic        START;
  logic        ABORT;
  logic        IMG_RESET;
  logic [31:0] Exp_subc;
  logic [31:0] Num_Pat;
  logic        FSMIND1;
  logic        FSMIND1ACK;
  logic        FSMIND0;
  logic        FSMIND0ACK;
  logic        RO_START;
  logic        RO_DONE;
  logic        BUSY;
  logic [15:0] FRAME_CNT;
  logic        ERR;
  logic [7:0]  sched_stat;

  imager_frame_scheduler #(.C_WDOG(WDOG)) dut (
    .CLKMPRE    (CLKMPRE),
    .RESET      (RESET),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_EXP    (CFG_EXP),
    .CFG_NPAT   (CFG_NPAT),
    .TBL_LAST   (TBL_LAST),
    .NUM_FRAMES (NUM_FRAMES),
    .LOOP       (LOOP),
    .START      (START),
    .ABORT      (ABORT),
    .IMG_RESET  (IMG_RESET),
    .Exp_subc   (Exp_subc),
    .Num_Pat    (Num_Pat),
    .FSMIND1    (FSMIND1),
    .FSMIND1ACK (FSMIND1ACK),
    .FSMIND0    (FSMIND0),
    .FSMIND0ACK (FSMIND0ACK),
    .RO_START   (RO_START),
    .RO_DONE    (RO_DONE),
    .BUSY       (BUSY),
    .FRAME_CNT  (FRAME_CNT),
    .ERR        (ERR),
    .sched_stat (sched_stat)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  typedef struct { logic [31:0] exposure; logic [31:0] npat; } frame_t;
  typedef struct { logic [15:0] cnt; logic err; } run_t;

  frame_t frame_q [$];
  run_t   run_q [$];
  int     check_cnt = 0;
  int     pass_cnt  = 0;

  // Behavioural peer knobs and measurements
  int exp_en     = 1;
  int ack_delay  = 1;
  int ind0_len   = 0;
  int ind0_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_frame(input logic [31:0] e, input logic [31:0] n);
    frame_t f;
    f.exposure = e;
    f.npat     = n;
    frame_q.push_back(f);
  endtask

  task automatic push_run(input logic [15:0] c, input logic e);
    run_t r;
    r.cnt = c;
    r.err = e;
    run_q.push_back(r);
  endtask

  // Monitor: compare table values at each readout trigger and results at STOP.
  initial begin
    frame_t f;
    run_t   r;
    forever begin
      @(negedge CLKMPRE);
      if (FSMIND0 === 1'b1) ind0_total++;
      if (RO_START === 1'b1) begin
        if (frame_q.size() == 0) check("ro_start_unexpected", 32'd1, 32'd0);
        else begin
          f = frame_q.pop_front();
          check("exp_subc", Exp_subc, f.exposure);
          check("num_pat", Num_Pat, f.npat);
        end
      end
      if (sched_stat === 8'h20) begin
        if (run_q.size() == 0) check("stop_unexpected", 32'd1, 32'd0);
        else begin
          r = run_q.pop_front();
          check("stop_frame_cnt", FRAME_CNT, r.cnt);
          check("stop_err", ERR, r.err);
          check("stop_img_reset", IMG_RESET, 1);
          check("stop_busy", BUSY, 0);
          check("stop_fsmind1ack", FSMIND1ACK, 0);
          check("stop_fsmind0", FSMIND0, 0);
        end
      end
    end
  end

  // Exposure model: raise FSMIND1 after 3 RUN cycles, drop it once acknowledged.
  initial begin
    int cnt;
    cnt = 0;
    FSMIND1 = 1'b0;
    forever begin
      @(negedge CLKMPRE);
      if (FSMIND1) begin
        if (FSMIND1ACK || sched_stat == 8'h00) FSMIND1 = 1'b0;
      end else if (exp_en != 0 && sched_stat == 8'h02) begin
        cnt++;
        if (cnt >= 3) begin
          FSMIND1 = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Readout model: RO_DONE pulse 5 cycles after each RO_START.
  initial begin
    int cnt;
    cnt = 0;
    RO_DONE = 1'b0;
    forever begin
      @(negedge CLKMPRE);
      if (RO_DONE) RO_DONE = 1'b0;
      if (RO_START) cnt = 5;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) RO_DONE = 1'b1;
      end
    end
  end

  // Next-frame model: acknowledge FSMIND0 after it has been seen ack_delay cycles.
  initial begin
    int run_len;
    run_len = 0;
    FSMIND0ACK = 1'b0;
    forever begin
      @(negedge CLKMPRE);
      if (FSMIND0ACK) begin
        FSMIND0ACK = 1'b0;
        run_len = 0;
      end else if (FSMIND0) begin
        run_len++;
        if (run_len >= ack_delay) begin
          FSMIND0ACK = 1'b1;
          ind0_len = run_len;
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic wait_stat(input logic [7:0] code, input int budget, input string name);
    int n;
    n = 0;
    while (sched_stat !== code && n < budget) begin
      @(negedge CLKMPRE);
      n++;
    end
    if (sched_stat !== code) check(name, sched_stat, code);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] e, input logic [31:0] n);
    CFG_ADDR = a;
    CFG_EXP  = e;
    CFG_NPAT = n;
    CFG_WE   = 1'b1;
    @(negedge CLKMPRE);
    CFG_WE   = 1'b0;
  endtask

  task automatic start_run(input logic [2:0] last, input logic [15:0] nf, input logic lp);
    TBL_LAST   = last;
    NUM_FRAMES = nf;
    LOOP       = lp;
    START      = 1'b1;
    @(negedge CLKMPRE);
    START      = 1'b0;
  endtask

  task automatic finish_run(input string name);
    wait_stat(8'h00, 3000, name);
    repeat (10) @(negedge CLKMPRE);
  endtask

  // Global guard so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ro_n;
    RESET = 1'b1; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_EXP = '0; CFG_NPAT = '0;
    TBL_LAST = '0; NUM_FRAMES = '0; LOOP = 1'b0; START = 1'b0; ABORT = 1'b0;
    repeat (3) @(negedge CLKMPRE);
    check("rst_stat", sched_stat, 8'h00);
    check("rst_img_reset", IMG_RESET, 1);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    check("rst_frame_cnt", FRAME_CNT, 0);
    check("rst_exp_subc", Exp_subc, 0);
    check("rst_num_pat", Num_Pat, 0);
    check("rst_fsmind0", FSMIND0, 0);
    check("rst_fsmind1ack", FSMIND1ACK, 0);
    check("rst_ro_start", RO_START, 0);
    RESET = 1'b0;
    @(negedge CLKMPRE);

    // Default table contents on entries 0 and 1
    push_frame(10, 100); push_frame(10, 100); push_run(2, 0);
    start_run(3'd1, 16'd2, 1'b0);
    finish_run("defaults_done");

    // Configured table, three frames wrapping at TBL_LAST=1
    cfg_write(3'd0, 32'd10, 32'd100);
    cfg_write(3'd1, 32'd20, 32'd50);
    cfg_write(3'd2, 32'd7, 32'd0);
    push_frame(10, 100); push_frame(20, 50); push_frame(10, 100); push_run(3, 0);
    start_run(3'd1, 16'd3, 1'b0);
    finish_run("three_done");
    check("idle_img_reset", IMG_RESET, 1);
    check("idle_busy", BUSY, 0);

    // NUM_FRAMES=0 without LOOP: error, no run
    start_run(3'd1, 16'd0, 1'b0);
    repeat (2) @(negedge CLKMPRE);
    check("zero_err", ERR, 1);
    check("zero_stat", sched_stat, 8'h00);
    check("zero_img_reset", IMG_RESET, 1);

    // Watchdog: exposure never completes
    exp_en = 0;
    push_run(0, 1);
    start_run(3'd0, 16'd1, 1'b0);
    wait_stat(8'h02, 10, "wdog_enter_run");
    n = 0;
    while (sched_stat === 8'h02 && n < 200) begin
      n++;
      @(negedge CLKMPRE);
    end
    check("wdog_run_cycles", n, WDOG);
    check("wdog_stop", sched_stat, 8'h20);
    check("wdog_err", ERR, 1);
    finish_run("wdog_done");
    check("wdog_idle", sched_stat, 8'h00);
    exp_en = 1;

    // Delayed FSMIND0ACK; entry 2 also checks Num_Pat=0 passes through
    ack_delay = 7;
    ind0_total = 0;
    push_frame(10, 100); push_frame(20, 50); push_frame(7, 0); push_run(3, 0);
    start_run(3'd2, 16'd3, 1'b0);
    finish_run("delay_done");
    check("ind0_len", ind0_len, 7);
    check("ind0_total", ind0_total, 14);
    ack_delay = 1;

    // Write attempted during RUN must be dropped
    push_frame(10, 100); push_run(1, 0);
    start_run(3'd1, 16'd1, 1'b0);
    wait_stat(8'h02, 10, "cfg_run_enter");
    cfg_write(3'd1, 32'd99, 32'd99);
    finish_run("cfg_run_done");
    push_frame(10, 100); push_frame(20, 50); push_run(2, 0);
    start_run(3'd1, 16'd2, 1'b0);
    finish_run("cfg_check_done");

    // LOOP run aborted in the fifth READOUT, after four completed frames
    push_frame(10, 100); push_frame(20, 50); push_frame(10, 100);
    push_frame(20, 50); push_frame(10, 100); push_run(4, 0);
    start_run(3'd1, 16'd0, 1'b1);
    ro_n = 0;
    n = 0;
    while (n < 3000) begin
      if (RO_START) ro_n++;
      if (ro_n == 5) break;
      @(negedge CLKMPRE);
      n++;
    end
    check("loop_ro_starts", ro_n, 5);
    ABORT = 1'b1;
    @(negedge CLKMPRE);
    ABORT = 1'b0;
    LOOP  = 1'b0;
    check("abort_stop", sched_stat, 8'h20);
    check("abort_fsmind1ack", FSMIND1ACK, 0);
    finish_run("abort_done");

    // RESET during READOUT; table must revert to defaults afterwards
    push_frame(10, 100);
    start_run(3'd0, 16'd1, 1'b0);
    n = 0;
    while (RO_START !== 1'b1 && n < 500) begin
      @(negedge CLKMPRE);
      n++;
    end
    check("mid_ro_start", RO_START, 1);
    RESET = 1'b1;
    @(negedge CLKMPRE);
    check("mid_rst_stat", sched_stat, 8'h00);
    check("mid_rst_img_reset", IMG_RESET, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_fsmind1ack", FSMIND1ACK, 0);
    check("mid_rst_exp_subc", Exp_subc, 0);
    check("mid_rst_num_pat", Num_Pat, 0);
    check("mid_rst_ro_start", RO_START, 0);
    RESET = 1'b0;
    repeat (10) @(negedge CLKMPRE);
    push_frame(10, 100); push_frame(10, 100); push_run(2, 0);
    start_run(3'd1, 16'd2, 1'b0);
    finish_run("post_reset_done");

    check("frame_q_empty", frame_q.size(), 0);
    check("run_q_empty", run_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/imager_frame_scheduler.md
IMAGER_FRAME_SCHEDULER -- requirements
Module: imager_frame_scheduler

Interface
REQ-001 SHALL have parameter C_TBL_DEPTH, default 8: frame-config table entries (power of 2).
REQ-002 SHALL have parameter C_WDOG, default 16777216: maximum CLKMPRE cycles in RUN without FSMIND1.
REQ-003 SHALL have parameter C_EXP_DEF, default 10: reset exposure per table entry.
REQ-004 SHALL have parameter C_NPAT_DEF, default 100: reset pattern count per table entry.
REQ-005 SHALL have ports, clock and reset first:
- CLKMPRE  in  1  single clock.
- RESET  in  1  synchronous, active-high.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  3  table index.
- CFG_EXP  in  32  exposure value, x100 CLK_HS.
- CFG_NPAT  in  32  pattern count.
- TBL_LAST  in  3  last table index used.
- NUM_FRAMES  in  16  frames per run.
- LOOP  in  1  run until ABORT.
- START  in  1  one-cycle run request.
- ABORT  in  1  stop the run.
- IMG_RESET  out  1  holds the exposure FSM in reset.
- Exp_subc  out  32  to exposure FSM.
- Num_Pat  out  32  to exposure FSM.
- FSMIND1  in  1  exposure done.
- FSMIND1ACK  out  1  ack for FSMIND1.
- FSMIND0  out  1  start the next frame.
- FSMIND0ACK  in  1  ack for FSMIND0.
- RO_START  out  1  one-cycle readout trigger.
- RO_DONE  in  1  readout complete.
- BUSY  out  1  run active.
- FRAME_CNT  out  16  completed frames.
- ERR  out  1  sticky error.
- sched_stat  out  8  state code.

Function
REQ-006 SHALL accept a CFG_WE write only in IDLE; a write in any other state SHALL be dropped.
REQ-007 SHALL handle START in IDLE as follows:
- NUM_FRAMES=0 with LOOP=0: set ERR and stay in IDLE.
- otherwise: set index=0, clear FRAME_CNT and ERR, go to LOAD.
REQ-008 SHALL ignore START outside IDLE.
REQ-009 In LOAD (1 cycle), SHALL drive Exp_subc/Num_Pat from table[index], deassert IMG_RESET, set BUSY=1, and go to RUN.
REQ-010 SHALL hold Exp_subc and Num_Pat stable from LOAD until the next NEXT or IDLE.
REQ-011 In RUN, SHALL count cycles.
- FSMIND1=1: go to ACK1.
- count reaches C_WDOG: set ERR and go to STOP.
REQ-012 In ACK1 (1 cycle), SHALL assert FSMIND1ACK, pulse RO_START, and go to READOUT.
REQ-013 In READOUT, SHALL hold FSMIND1ACK=1 and wait for RO_DONE.
- On RO_DONE: increment FRAME_CNT, wrapping 16-bit.
- If LOOP=1 or FRAME_CNT+1 < NUM_FRAMES: go to NEXT.
- Otherwise: go to STOP.
REQ-014 On NEXT entry, SHALL set index = (index==TBL_LAST) ? 0 : index+1 and load Exp_subc/Num_Pat from table[index].
REQ-015 In NEXT, SHALL assert FSMIND0 until FSMIND0ACK=1; in the ack cycle it SHALL deassert FSMIND0 and FSMIND1ACK and go to RUN.
REQ-016 In STOP (1 cycle), SHALL set IMG_RESET=1, FSMIND0=0, FSMIND1ACK=0, BUSY=0, and go to IDLE.
REQ-017 ABORT in any non-IDLE state SHALL go to STOP next cycle and take priority over all other transitions; ABORT in IDLE SHALL have no effect.
REQ-018 RO_DONE outside READOUT and FSMIND0ACK outside NEXT SHALL be ignored.
REQ-019 SHALL pass CFG values through unchanged, including Num_Pat=0.
REQ-020 sched_stat SHALL encode IDLE=0x00, LOAD=0x01, RUN=0x02, ACK1=0x04, READOUT=0x08, NEXT=0x10, STOP=0x20.
REQ-021 Illegal state encodings SHALL recover to STOP.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On RESET, SHALL set:
- state=IDLE, IMG_RESET=1.
- all other outputs 0; sched_stat=0x00; FRAME_CNT=0; ERR=0.
- every table entry to C_EXP_DEF/C_NPAT_DEF.
REQ-024 RESET mid-run SHALL take effect in the next cycle regardless of handshake state.

Structure
REQ-025 Shared package imager_pkg SHALL hold the state encodings, C_TBL_DEPTH, C_EXP_DEF, C_NPAT_DEF and C_WDOG.
REQ-026 The table SHALL be sub-module imager_cfg_table: registered, with 1 write port and 1 read port.

Verification
REQ-027 Bench SHALL cover:
- Table entries 0/1 = (10,100)/(20,50), TBL_LAST=1, NUM_FRAMES=3, START, exposure model asserts FSMIND1, RO_DONE after 5 cycles -> Exp_subc 10, 20, 10 across frames; FRAME_CNT=3; IMG_RESET=1 and BUSY=0 after STOP.
- START with NUM_FRAMES=0, LOOP=0 -> ERR=1, state stays 0x00, IMG_RESET stays 1.
- C_WDOG=64, FSMIND1 never asserted -> ERR=1 on cycle 64 of RUN, STOP, then IDLE.
- LOOP=1, ABORT asserted in READOUT after 4 frames -> STOP next cycle, FSMIND1ACK=0, FRAME_CNT=4.
- FSMIND0ACK delayed 7 cycles in NEXT -> FSMIND0 held 7 cycles, then RUN, Exp_subc unchanged in RUN.
- CFG_WE during RUN -> table unchanged, verified by the next run's outputs; RESET mid-READOUT -> all outputs at reset values next cycle.
